// File: rtl/alarm_ctrl_multizone.sv
// Multi-zone alarm controller: keypad arm/disarm, exit/entry delays,
// wrong-key limit and siren auto-timeout over N_ZONES supervised sensors.
module alarm_ctrl_multizone #(
    parameter int unsigned N_ZONES   = 4,
    parameter int unsigned EXIT_DLY  = 16,
    parameter int unsigned ENTRY_DLY = 16,
    parameter int unsigned SIREN_MAX = 64,
    parameter int unsigned MAX_ERR   = 3,
    parameter int unsigned CNT_W     = 8
) (
    input  logic               SERCLK_OUT,
    input  logic               RESET_IN,
    input  logic [1:0]         KEY_STATUS,
    input  logic               KEY_VALID,
    input  logic [N_ZONES-1:0] ZONE_IN,
    input  logic [N_ZONES-1:0] ZONE_DELAYED,
    input  logic [N_ZONES-1:0] ZONE_EN,
    output logic               SIREN_OUT,
    output logic [2:0]         STATE,
    output logic               ARMED,
    output logic [N_ZONES-1:0] ALARM_ZONES,
    output logic [CNT_W-1:0]   ERR_CNT,
    output logic               KEY_ACK
);

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        SALIDA   = 3'd1,
        ARMADO   = 3'd2,
        ESPERA   = 3'd3,
        ALARMA   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_LAST  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SIREN_LAST = CNT_W'(SIREN_MAX - 1);
    localparam logic [CNT_W-1:0] ERR_LIM    = CNT_W'(MAX_ERR);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   timer_q, timer_n;
    logic [CNT_W-1:0]   err_q, err_n, err_inc;
    logic [N_ZONES-1:0] zones_q, zones_n;
    logic               siren_q, siren_n;
    logic               armed_q, armed_n;
    logic               ack_q;
    logic               retrig;

    logic               key_ok, key_err, err_hit;
    logic [N_ZONES-1:0] inst, dly, trip;

    // Key event decode and zone classification
    assign key_ok  = KEY_VALID && (KEY_STATUS == 2'd0);
    assign key_err = KEY_VALID && (KEY_STATUS == 2'd2);
    assign inst    = ZONE_IN & ZONE_EN & ~ZONE_DELAYED;
    assign dly     = ZONE_IN & ZONE_EN & ZONE_DELAYED;
    assign trip    = inst | dly;
    assign err_inc = (err_q == CNT_SAT) ? err_q : err_q + CNT_W'(1);
    assign err_hit = key_err && (err_inc >= ERR_LIM);

    // Next-state, timer, error counter and output decode
    always_comb begin
        state_n = state_q;
        retrig  = 1'b0;
        err_n   = err_q;
        timer_n = timer_q;
        zones_n = zones_q;
        if (key_err) err_n = err_inc;
        if (key_ok)  err_n = '0;

        case (state_q)
            INACTIVO: begin
                if (key_ok)                               state_n = SALIDA;
                else if (key_err && (err_q >= ERR_LIM))   err_n   = err_q;
            end
            SALIDA: begin
                if (key_ok)                     state_n = INACTIVO;
                else if (timer_q == EXIT_LAST)  state_n = ARMADO;
            end
            ARMADO: begin
                if (key_ok)                     state_n = INACTIVO;
                else if (err_hit || (|inst))    state_n = ALARMA;
                else if (|dly)                  state_n = ESPERA;
            end
            ESPERA: begin
                if (key_ok)                     state_n = INACTIVO;
                else if (err_hit || (|inst) || (timer_q == ENTRY_LAST))
                                                state_n = ALARMA;
            end
            ALARMA: begin
                if (key_ok)                     state_n = INACTIVO;
                else if ((|trip) && (timer_q > SIREN_LAST))
                                                retrig  = 1'b1;
            end
            default:                            state_n = INACTIVO;
        endcase

        if ((state_n != state_q) || retrig)
            timer_n = '0;
        else if (((state_q == SALIDA) || (state_q == ESPERA) || (state_q == ALARMA))
                 && (timer_q != CNT_SAT))
            timer_n = timer_q + CNT_W'(1);

        // Zone record clears leaving for INACTIVO, accumulates on alarm-path entry
        if (state_n == INACTIVO) begin
            if (state_q != INACTIVO) begin
                zones_n = '0;
                err_n   = '0;
            end
        end else if (((state_n != state_q) && ((state_n == ESPERA) || (state_n == ALARMA)))
                     || (state_q == ALARMA)) begin
            zones_n = zones_q | trip;
        end

        siren_n = (state_n == ALARMA) && (timer_n <= SIREN_LAST);
        armed_n = (state_n == SALIDA) || (state_n == ARMADO) ||
                  (state_n == ESPERA) || (state_n == ALARMA);
    end

    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q <= INACTIVO;
            timer_q <= '0;
            err_q   <= '0;
            zones_q <= '0;
            siren_q <= 1'b0;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            err_q   <= err_n;
            zones_q <= zones_n;
            siren_q <= siren_n;
            armed_q <= armed_n;
            ack_q   <= KEY_VALID;
        end
    end

    assign STATE       = state_q;
    assign SIREN_OUT   = siren_q;
    assign ARMED       = armed_q;
    assign ALARM_ZONES = zones_q;
    assign ERR_CNT     = err_q;
    assign KEY_ACK     = ack_q;

endmodule

// File: tb/tb_alarm_ctrl_multizone.sv
// Scoreboard bench for alarm_ctrl_multizone: expected outputs are queued with
// each driven cycle and compared one clock later.
module tb_alarm_ctrl_multizone;

    localparam int unsigned NZ = 4;
    localparam int unsigned CW = 8;

    localparam int S_STATE = 0;
    localparam int S_SIREN = 1;
    localparam int S_ARMED = 2;
    localparam int S_ZONES = 3;
    localparam int S_ERR   = 4;
    localparam int S_ACK   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    key_status = 2'd3;
    logic          key_valid = 1'b0;
    logic [NZ-1:0] zone_in = '0;
    logic [NZ-1:0] zone_delayed = 4'b0011;
    logic [NZ-1:0] zone_en = 4'b0111;
    logic          siren;
    logic [2:0]    state;
    logic          armed;
    logic [NZ-1:0] alarm_zones;
    logic [CW-1:0] err_cnt;
    logic          key_ack;

    alarm_ctrl_multizone dut (
        .SERCLK_OUT   (clk),
        .RESET_IN     (rst),
        .KEY_STATUS   (key_status),
        .KEY_VALID    (key_valid),
        .ZONE_IN      (zone_in),
        .ZONE_DELAYED (zone_delayed),
        .ZONE_EN      (zone_en),
        .SIREN_OUT    (siren),
        .STATE        (state),
        .ARMED        (armed),
        .ALARM_ZONES  (alarm_zones),
        .ERR_CNT      (err_cnt),
        .KEY_ACK      (key_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_STATE: observe = 32'(state);
            S_SIREN: observe = 32'(siren);
            S_ARMED: observe = 32'(armed);
            S_ZONES: observe = 32'(alarm_zones);
            S_ERR:   observe = 32'(err_cnt);
            default: observe = 32'(key_ack);
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs, then compare everything queued for it
    task automatic cycle(input logic kv, input logic [1:0] ks, input logic [NZ-1:0] z);
        exp_t e;
        @(negedge clk);
        key_valid  = kv;
        key_status = ks;
        zone_in    = z;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic idle(input logic [NZ-1:0] z);
        cycle(1'b0, 2'd3, z);
    endtask

    task automatic key_ok();
        cycle(1'b1, 2'd0, '0);
    endtask

    task automatic key_err();
        cycle(1'b1, 2'd2, '0);
    endtask

    // Arm from INACTIVO with all zones tripped during the exit delay
    task automatic arm(input string tag);
        expect_out({tag, "_salida"}, S_STATE, 1);
        expect_out({tag, "_armed"}, S_ARMED, 1);
        expect_out({tag, "_ack"}, S_ACK, 1);
        key_ok();
        for (int i = 0; i < 15; i++) begin
            expect_out({tag, "_exit_hold"}, S_STATE, 1);
            idle(4'b1111);
        end
        expect_out({tag, "_armado"}, S_STATE, 2);
        expect_out({tag, "_noack"}, S_ACK, 0);
        idle(4'b1111);
        expect_out({tag, "_armado_stay"}, S_STATE, 2);
        expect_out({tag, "_no_zones"}, S_ZONES, 0);
        idle('0);
    endtask

    task automatic disarm(input string tag);
        expect_out({tag, "_inactivo"}, S_STATE, 0);
        expect_out({tag, "_siren_off"}, S_SIREN, 0);
        expect_out({tag, "_unarmed"}, S_ARMED, 0);
        expect_out({tag, "_zones_clr"}, S_ZONES, 0);
        expect_out({tag, "_err_clr"}, S_ERR, 0);
        key_ok();
    endtask

    initial begin
        #12;
        check("rst_state", 32'(state), 0);
        check("rst_siren", 32'(siren), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_zones", 32'(alarm_zones), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_ack", 32'(key_ack), 0);
        @(negedge clk);
        rst = 1'b0;

        // Exit delay, bypassed zone, entry delay to alarm
        arm("arm1");
        for (int i = 0; i < 3; i++) begin
            expect_out("bypass_stay", S_STATE, 2);
            idle(4'b1000);
        end
        expect_out("entry_espera", S_STATE, 3);
        expect_out("entry_zones", S_ZONES, 4'b0001);
        expect_out("entry_siren0", S_SIREN, 0);
        idle(4'b0001);
        for (int i = 0; i < 15; i++) begin
            expect_out("entry_hold", S_STATE, 3);
            expect_out("entry_quiet", S_SIREN, 0);
            idle('0);
        end
        expect_out("entry_alarma", S_STATE, 4);
        expect_out("entry_siren1", S_SIREN, 1);
        expect_out("entry_zones_a", S_ZONES, 4'b0001);
        idle('0);
        disarm("dis1");

        // Disarm on the last cycle of the entry delay
        arm("arm2");
        expect_out("late_espera", S_STATE, 3);
        idle(4'b0001);
        for (int i = 0; i < 15; i++) begin
            expect_out("late_hold", S_STATE, 3);
            idle('0);
        end
        disarm("late_ok");

        // Instant zone while in ESPERA
        arm("arm3");
        expect_out("inst_espera", S_STATE, 3);
        idle(4'b0001);
        expect_out("inst_alarma", S_STATE, 4);
        expect_out("inst_zones", S_ZONES, 4'b0101);
        expect_out("inst_siren", S_SIREN, 1);
        idle(4'b0100);
        disarm("dis3");

        // Wrong-key limit in ARMADO
        arm("arm4");
        expect_out("err1_cnt", S_ERR, 1);
        expect_out("err1_state", S_STATE, 2);
        key_err();
        expect_out("err2_cnt", S_ERR, 2);
        expect_out("err2_state", S_STATE, 2);
        key_err();
        expect_out("err3_cnt", S_ERR, 3);
        expect_out("err3_state", S_STATE, 4);
        expect_out("err3_siren", S_SIREN, 1);
        key_err();
        disarm("dis4");

        // Siren timeout and re-trigger
        arm("arm5");
        expect_out("sir_alarma", S_STATE, 4);
        expect_out("sir_on0", S_SIREN, 1);
        expect_out("sir_zones", S_ZONES, 4'b0100);
        idle(4'b0100);
        for (int i = 0; i < 63; i++) begin
            expect_out("sir_on", S_SIREN, 1);
            idle('0);
        end
        for (int i = 0; i < 4; i++) begin
            expect_out("sir_off", S_SIREN, 0);
            expect_out("sir_off_state", S_STATE, 4);
            idle('0);
        end
        expect_out("sir_retrig", S_SIREN, 1);
        expect_out("sir_retrig_zones", S_ZONES, 4'b0110);
        idle(4'b0010);
        for (int i = 0; i < 63; i++) begin
            expect_out("sir_on2", S_SIREN, 1);
            idle('0);
        end
        expect_out("sir_off2", S_SIREN, 0);
        idle('0);
        disarm("dis5");

        // Key errors while idle saturate at the limit; NO_KEY/reserved still ack
        for (int i = 1; i <= 4; i++) begin
            expect_out("idle_err_cnt", S_ERR, (i > 3) ? 3 : i);
            expect_out("idle_err_state", S_STATE, 0);
            key_err();
        end
        expect_out("nokey_ack", S_ACK, 1);
        expect_out("nokey_state", S_STATE, 0);
        cycle(1'b1, 2'd3, '0);
        expect_out("rsv_ack", S_ACK, 1);
        expect_out("rsv_err", S_ERR, 3);
        cycle(1'b1, 2'd1, '0);
        expect_out("noval_ack", S_ACK, 0);
        expect_out("noval_state", S_STATE, 0);
        cycle(1'b0, 2'd0, '0);

        // Async reset in the middle of ESPERA
        arm("arm6");
        expect_out("rst_espera", S_STATE, 3);
        idle(4'b0001);
        idle('0);
        #3;
        rst = 1'b1;
        #1;
        check("async_state", 32'(state), 0);
        check("async_siren", 32'(siren), 0);
        check("async_armed", 32'(armed), 0);
        @(negedge clk);
        rst = 1'b0;
        arm("arm7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_ctrl_multizone.md
Name: alarm_ctrl_multizone

Overview:
Multi-zone successor of the home-alarm main controller. It arms and disarms from keypad status codes and supervises N_ZONES sensor inputs, each configurable as instant, delayed or bypassed. It adds an exit delay, an entry delay counted internally, a wrong-key attempt limit and siren auto-timeout. It sits between the keypad decoder (KEY_STATUS/KEY_VALID) and the siren driver / status reporting path.

Parameters:
N_ZONES, 4, number of sensor zones (1..16)
EXIT_DLY, 16, cycles spent in SALIDA before ARMADO (>=1)
ENTRY_DLY, 16, cycles spent in ESPERA before ALARMA (>=1)
SIREN_MAX, 64, cycles the siren sounds before auto-silence (>=1)
MAX_ERR, 3, consecutive KEY_ERROR events that force ALARMA (>=1; 1 = immediate)
CNT_W, 8, timer width; must hold max(EXIT_DLY, ENTRY_DLY, SIREN_MAX)

Ports:
SERCLK_OUT  input  1  system clock, rising edge
RESET_IN  input  1  reset, asynchronous, active-high
KEY_STATUS  input  2  0=KEY_OK, 2=KEY_ERROR, 3=NO_KEY, 1=reserved (treated as NO_KEY)
KEY_VALID  input  1  one-cycle strobe qualifying KEY_STATUS
ZONE_IN  input  N_ZONES  sensor levels, 1 = tripped, synchronous to SERCLK_OUT
ZONE_DELAYED  input  N_ZONES  1 = delayed zone (door), 0 = instant zone (window)
ZONE_EN  input  N_ZONES  1 = zone supervised, 0 = bypassed
SIREN_OUT  output  1  siren drive
STATE  output  3  current state encoding
ARMED  output  1  high in SALIDA, ARMADO, ESPERA, ALARMA
ALARM_ZONES  output  N_ZONES  sticky record of zones that caused or joined the alarm
ERR_CNT  output  CNT_W  consecutive key-error count
KEY_ACK  output  1  one-cycle pulse, the cycle after an accepted KEY_VALID

Behaviour:
- Reset values (async): STATE=INACTIVO, SIREN_OUT=0, ARMED=0, ALARM_ZONES=0, ERR_CNT=0, KEY_ACK=0, timer=0. Reset mid-operation aborts any delay and silences the siren immediately.
- All outputs are registered. STATE encodings: INACTIVO=0, SALIDA=1, ARMADO=2, ESPERA=3, ALARMA=4. Encodings 5-7 go to INACTIVO on the next edge.
- A key event is KEY_VALID=1 with KEY_STATUS=0 or 2. KEY_STATUS is ignored when KEY_VALID=0.
- Active zones: inst = ZONE_IN & ZONE_EN & ~ZONE_DELAYED; dly = ZONE_IN & ZONE_EN & ZONE_DELAYED.
- Timer: cleared on every state change. Otherwise increments each cycle in SALIDA, ESPERA and ALARMA, saturating at all-ones.
- INACTIVO: KEY_OK -> SALIDA. KEY_ERROR increments ERR_CNT only, with no transition. Zones are ignored.
- SALIDA: zones are ignored. KEY_OK -> INACTIVO (cancel). The state moves to ARMADO when timer == EXIT_DLY-1.
- ARMADO, in priority order:
  1. KEY_OK -> INACTIVO.
  2. KEY_ERROR that makes ERR_CNT reach MAX_ERR -> ALARMA.
  3. Any inst bit -> ALARMA.
  4. Any dly bit -> ESPERA.
- ESPERA, in priority order:
  1. KEY_OK -> INACTIVO. KEY_OK wins over a simultaneous timeout or trip.
  2. Error limit reached -> ALARMA.
  3. Any inst bit -> ALARMA.
  4. timer == ENTRY_DLY-1 -> ALARMA.
  Consequence: the alarm fires exactly ENTRY_DLY cycles after ESPERA is entered.
- ALARMA: KEY_OK -> INACTIVO. KEY_ERROR only counts.
  - SIREN_OUT = 1 from ALARMA entry until timer == SIREN_MAX-1, then 0 while the state stays ALARMA.
  - A new inst or dly trip in ALARMA after silence clears the timer and re-sounds the siren for another SIREN_MAX cycles.
- ALARM_ZONES: OR-accumulates (inst|dly) on the edge of each transition into ESPERA or ALARMA, and every cycle while in ALARMA. It clears only on the transition to INACTIVO.
- ERR_CNT: +1 per KEY_ERROR event, saturating. It is cleared on any KEY_OK event and on entry to INACTIVO. When the counter reaches MAX_ERR in INACTIVO, it holds with no transition.
- KEY_ACK: pulses for every key event, including NO_KEY with KEY_VALID=1.
- ARMED and SIREN_OUT are decoded from registered state/timer and are glitch-free.

Test Plan:
- Arm: KEY_OK strobe in INACTIVO, EXIT_DLY=16 -> STATE=1 next cycle, STATE=2 exactly 16 cycles later; ZONE_IN=4'b1111 during SALIDA -> no alarm.
- Entry delay: in ARMADO, trip delayed zone 0 -> ESPERA, ALARMA after 16 cycles, SIREN_OUT=1, ALARM_ZONES=4'b0001. Repeat with KEY_OK at cycle 15 -> INACTIVO, SIREN_OUT stays 0.
- Instant zone: in ESPERA, trip instant zone 2 -> ALARMA next edge, ALARM_ZONES includes bit 2. Bypassed zone (ZONE_EN=0) tripped in ARMADO -> STATE stays 2.
- Wrong keys: MAX_ERR=3, three KEY_ERROR strobes in ARMADO -> ALARMA on the third, ERR_CNT=3. KEY_OK -> INACTIVO, ERR_CNT=0, ALARM_ZONES=0.
- Siren timeout: SIREN_MAX=64 -> SIREN_OUT high 64 cycles then low with STATE=4; a new trip -> SIREN_OUT high again for 64 cycles.
- Async reset asserted mid-ESPERA between clock edges -> immediately STATE=0, SIREN_OUT=0, ARMED=0; after release, KEY_OK arms normally.
